// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, default data width
// and the 2-bit FSM state encoding.
package alu_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT    = 2'b10,
    ST_RESPOND = 2'b11
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from two valids and a
// pointer; the pointer moves to the other requester on every accept.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant_any,
  output logic grant_idx
);

  logic ptr;

  always_comb begin
    grant_any = valid0 | valid1;
    if (valid0 && valid1) grant_idx = ptr;
    else                  grant_idx = valid1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~grant_idx;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters: round-robin accept, one
// ENABLE pulse, fixed-latency wait, then a held response to the owner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  output logic             resp1_valid,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic [3:0]       resp_flags,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  output logic [1:0]       alu_operation,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             owner
);

  localparam int unsigned CNT_W = 4;

  state_e           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_any, grant_idx, accept, div_zero, owner_ready;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;

  rr_arb2 u_arb (
    .clk      (CLK),
    .rst_n    (RESET),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .accept   (accept),
    .grant_any(grant_any),
    .grant_idx(grant_idx)
  );

  // Ready is gated by RESET so both readies read 0 while reset is held.
  assign accept     = RESET && (state == ST_IDLE) && grant_any;
  assign req0_ready = accept && !grant_idx;
  assign req1_ready = accept &&  grant_idx;

  assign sel_a       = grant_idx ? req1_a  : req0_a;
  assign sel_b       = grant_idx ? req1_b  : req0_b;
  assign sel_op      = grant_idx ? req1_op : req0_op;
  assign div_zero    = (sel_op == OP_DIV) && (sel_b == '0);
  assign owner_ready = owner ? resp1_ready : resp0_ready;

  assign alu_enable  = (state == ST_ISSUE);
  assign busy        = (state != ST_IDLE);
  assign resp0_valid = (state == ST_RESPOND) && !owner;
  assign resp1_valid = (state == ST_RESPOND) &&  owner;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept) state_next = div_zero ? ST_RESPOND : ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (wait_cnt == '0) state_next = ST_RESPOND;
      ST_RESPOND: if (owner_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Divide-by-zero fills the response at accept time and never loads the ALU.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner         <= 1'b0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operation <= '0;
      wait_cnt      <= '0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_flags    <= '0;
      resp_err      <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant_idx;
        if (div_zero) begin
          resp_result <= '0;
          resp_carry  <= 1'b0;
          resp_flags  <= '0;
          resp_err    <= 1'b1;
        end else begin
          alu_operand_a <= sel_a;
          alu_operand_b <= sel_b;
          alu_operation <= sel_op;
        end
      end
      if (state == ST_ISSUE)
        wait_cnt <= CNT_W'(ALU_LATENCY - 1);
      else if (state == ST_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - CNT_W'(1);
      if (state == ST_WAIT && wait_cnt == '0) begin
        resp_result <= alu_result;
        resp_carry  <= alu_carry_out;
        resp_flags  <= alu_flags;
        resp_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand sequences for contention,
// backpressure, reset and latency, plus randomized traffic against a model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_ready [2];
  logic [7:0] req_a     [2];
  logic [7:0] req_b     [2];
  logic [1:0] req_op    [2];
  logic       resp_valid[2];
  logic       resp_ready[2];
  logic [7:0] resp_result, alu_a, alu_b, alu_res;
  logic       resp_carry, resp_err, alu_en, alu_c, busy, owner;
  logic [3:0] resp_flags, alu_f;
  logic [1:0] alu_op;

  logic       r3_valid, r3_ready, r3_ready1, s3_valid0, s3_valid1, s3_ready;
  logic [7:0] r3_a, r3_b, s3_result, alu3_a, alu3_b, alu3_res;
  logic [1:0] r3_op, alu3_op;
  logic       s3_carry, s3_err, alu3_en, alu3_c, busy3, owner3;
  logic [3:0] s3_flags, alu3_f;

  alu_arbiter #(.WIDTH(8), .ALU_LATENCY(1)) dut (
    .CLK(clk), .RESET(rst_n),
    .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
    .req0_ready(req_ready[0]), .req1_ready(req_ready[1]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req0_op(req_op[0]), .req1_op(req_op[1]),
    .resp0_valid(resp_valid[0]), .resp1_valid(resp_valid[1]),
    .resp0_ready(resp_ready[0]), .resp1_ready(resp_ready[1]),
    .resp_result(resp_result), .resp_carry(resp_carry), .resp_flags(resp_flags),
    .resp_err(resp_err), .alu_operand_a(alu_a), .alu_operand_b(alu_b),
    .alu_operation(alu_op), .alu_enable(alu_en), .alu_result(alu_res),
    .alu_carry_out(alu_c), .alu_flags(alu_f), .busy(busy), .owner(owner)
  );

  alu_arbiter #(.WIDTH(8), .ALU_LATENCY(3)) dut3 (
    .CLK(clk), .RESET(rst_n),
    .req0_valid(r3_valid), .req1_valid(1'b0),
    .req0_ready(r3_ready), .req1_ready(r3_ready1),
    .req0_a(r3_a), .req0_b(r3_b), .req1_a(8'h00), .req1_b(8'h00),
    .req0_op(r3_op), .req1_op(2'b00),
    .resp0_valid(s3_valid0), .resp1_valid(s3_valid1),
    .resp0_ready(s3_ready), .resp1_ready(1'b0),
    .resp_result(s3_result), .resp_carry(s3_carry), .resp_flags(s3_flags),
    .resp_err(s3_err), .alu_operand_a(alu3_a), .alu_operand_b(alu3_b),
    .alu_operation(alu3_op), .alu_enable(alu3_en), .alu_result(alu3_res),
    .alu_carry_out(alu3_c), .alu_flags(alu3_f), .busy(busy3), .owner(owner3)
  );

  // Reference ALU: {result, carry, flags}; flags = {zero, negative, carry, is_div}.
  function automatic logic [12:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]         s;
    logic signed [15:0] p;
    logic [7:0]         r;
    logic               c;
    s = '0; p = '0; r = '0; c = 1'b0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; end
      2'd2: begin p = $signed(a) * $signed(b); r = p[7:0]; c = (p != {{8{p[7]}}, p[7:0]}); end
      default: r = (b == 8'h00) ? 8'h00 : 8'($signed(a) / $signed(b));
    endcase
    return {r, c, (r == 8'h00), r[7], c, (op == 2'd3)};
  endfunction

  localparam logic [12:0] JUNK = 13'h14AA;

  // Clocked ALU models: result valid only during the cycle the arbiter must capture it.
  always @(posedge clk) begin
    if (alu_en) {alu_res, alu_c, alu_f} <= alu_ref(alu_op, alu_a, alu_b);
    else        {alu_res, alu_c, alu_f} <= JUNK;
  end

  logic [12:0] pend3;
  int          cnt3 = 0;
  always @(posedge clk) begin
    if (alu3_en) begin
      pend3 <= alu_ref(alu3_op, alu3_a, alu3_b);
      cnt3  <= 2;
      {alu3_res, alu3_c, alu3_f} <= JUNK;
    end else if (cnt3 == 1) begin
      {alu3_res, alu3_c, alu3_f} <= pend3;
      cnt3 <= 0;
    end else begin
      {alu3_res, alu3_c, alu3_f} <= JUNK;
      if (cnt3 != 0) cnt3 <= cnt3 - 1;
    end
  end

  int en_count1 = 0;
  always @(posedge clk) if (alu_en) en_count1 <= en_count1 + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[who] = v; req_op[who] = op; req_a[who] = a; req_b[who] = b;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin set_req(i, 1'b0, 2'd0, 8'h00, 8'h00); resp_ready[i] = 1'b0; end
    r3_valid = 1'b0; s3_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic await_grant(output int who, output int waited);
    who = -1; waited = 0;
    #1;
    while (who < 0 && waited < 50) begin
      if (req_ready[0] || req_ready[1]) begin
        chk("single ready", 32'(req_ready[0] & req_ready[1]), 0);
        who = req_ready[0] ? 0 : 1;
      end else begin
        @(posedge clk); #2; waited++;
      end
    end
    if (who < 0) chk("grant timeout", 0, 1);
  endtask

  // Called in the cycle after the accept edge; checks latency, data, stability under hold, then consumes.
  task automatic await_resp(input int who, input logic [7:0] exp_res, input logic [4:0] exp_cf,
                            input logic exp_err, input int exp_lat, input int hold, input string name);
    int c = 1;
    #1;
    while (!resp_valid[who] && c < 60) begin @(posedge clk); #2; c++; end
    chk({name, " latency"}, c, exp_lat);
    chk({name, " other resp idle"}, 32'(resp_valid[who ^ 1]), 0);
    chk({name, " result"}, resp_result, exp_res);
    chk({name, " err"}, 32'(resp_err), 32'(exp_err));
    chk({name, " carry/flags"}, {resp_carry, resp_flags}, exp_cf);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      chk({name, " held valid"}, 32'(resp_valid[who]), 1);
      chk({name, " held data"}, {resp_result, resp_carry, resp_flags, resp_err}, {exp_res, exp_cf, exp_err});
      chk({name, " no grant while busy"}, 32'(req_ready[0] | req_ready[1]), 0);
    end
    resp_ready[who] = 1'b1;
    @(posedge clk); #1;
    resp_ready[who] = 1'b0;
    #1;
    chk({name, " idle after take"}, 32'(busy), 0);
    chk({name, " resp dropped"}, 32'(resp_valid[who]), 0);
  endtask

  typedef struct {
    int         who;
    logic [1:0] op;
    logic [7:0] a, b, res;
    logic       err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int hold, input string name);
    int          g, w, en0;
    logic [12:0] ref_v;
    ref_v = v.err ? 13'h0 : alu_ref(v.op, v.a, v.b);
    en0 = en_count1;
    set_req(v.who, 1'b1, v.op, v.a, v.b);
    await_grant(g, w);
    chk({name, " grant"}, g, v.who);
    @(posedge clk); #1;
    req_valid[v.who] = 1'b0;
    #1;
    chk({name, " issue enable"}, 32'(alu_en), 32'(!v.err));
    if (!v.err) chk({name, " issue operands"}, {alu_a, alu_b, alu_op}, {v.a, v.b, v.op});
    await_resp(v.who, v.res, ref_v[4:0], v.err, v.err ? 1 : 3, hold, name);
    chk({name, " enable pulses"}, en_count1 - en0, v.err ? 0 : 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    int         acc;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  bit   rnd_done = 0;
  int   got = 0;

  task automatic drive_rand(input int who, input int n);
    logic [1:0] op;
    logic [7:0] a, b;
    bit         hs;
    int         w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
      if (op == 2'd3 && $urandom_range(0, 3) == 0) b = 8'h00;
      set_req(who, 1'b1, op, a, b);
      hs = 0; w = 0;
      while (!hs && w < 400) begin #1; hs = req_ready[who]; @(posedge clk); #1; w++; end
      if (!hs) chk("rand grant timeout", 0, 1);
      req_valid[who] = 1'b0;
    end
  endtask

  task automatic sink_rand(input int who);
    while (!rnd_done) begin
      resp_ready[who] = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    resp_ready[who] = 1'b0;
  endtask

  // Transaction-level model: per-requester FIFO order, strict alternation under contention, fixed latency.
  task automatic monitor();
    int          cyc = 0, last_g = 1;
    bit          prev_rv[2];
    txn_t        t;
    logic [12:0] e;
    bit          dz;
    prev_rv[0] = 0; prev_rv[1] = 0;
    while (!rnd_done) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_valid[0] && req_valid[1]) chk("rr alternation", i, 1 - last_g);
          last_g = i;
          t.op = req_op[i]; t.a = req_a[i]; t.b = req_b[i]; t.acc = cyc;
          if (i == 0) q0.push_back(t); else q1.push_back(t);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && !prev_rv[i]) begin
          chk("rand resp expected", 32'((i == 0) ? q0.size() : q1.size()) != 0, 1);
          if (((i == 0) ? q0.size() : q1.size()) != 0) begin
            t = (i == 0) ? q0[0] : q1[0];
            dz = (t.op == 2'd3) && (t.b == 8'h00);
            chk("rand latency", cyc - t.acc, dz ? 1 : 3);
          end
        end
        if (resp_valid[i] && resp_ready[i] && ((i == 0) ? q0.size() : q1.size()) != 0) begin
          t = (i == 0) ? q0.pop_front() : q1.pop_front();
          dz = (t.op == 2'd3) && (t.b == 8'h00);
          e = dz ? 13'h0 : alu_ref(t.op, t.a, t.b);
          chk("rand data", {resp_result, resp_carry, resp_flags, resp_err}, {e, dz});
          got++;
        end
        prev_rv[i] = resp_valid[i];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   g, w, c;
    vecs[0] = '{0, 2'd0, 8'hFB, 8'hFE, 8'hF9, 1'b0};
    vecs[1] = '{1, 2'd1, 8'hFD, 8'hFC, 8'h01, 1'b0};
    vecs[2] = '{1, 2'd2, 8'h05, 8'h03, 8'h0F, 1'b0};
    vecs[3] = '{1, 2'd3, 8'h15, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{1, 2'd3, 8'h15, 8'h03, 8'h07, 1'b0};
    vecs[5] = '{0, 2'd2, 8'hFC, 8'h06, 8'hE8, 1'b0};
    vecs[6] = '{0, 2'd3, 8'hEC, 8'h03, 8'hFA, 1'b0};
    vecs[7] = '{0, 2'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[8] = '{1, 2'd1, 8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[9] = '{0, 2'd3, 8'h07, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin set_req(i, 1'b0, 2'd0, 8'h00, 8'h00); resp_ready[i] = 1'b0; end
    r3_valid = 1'b0; r3_a = 8'h00; r3_b = 8'h00; r3_op = 2'd0; s3_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", 32'(busy), 0);
    chk("reset ctl", {alu_en, req_ready[0], req_ready[1], resp_valid[0], resp_valid[1], resp_err, owner}, 0);
    chk("reset alu outs", {alu_a, alu_b, alu_op}, 0);
    chk("reset resp data", {resp_result, resp_carry, resp_flags}, 0);
    chk("reset busy L3", 32'(busy3), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i % 3, $sformatf("vec%0d", i));

    // Contention: req0 first after reset, then strict alternation while both wait.
    reset_dut();
    set_req(0, 1'b1, 2'd1, 8'hFD, 8'hFC);
    set_req(1, 1'b1, 2'd2, 8'h05, 8'h03);
    await_grant(g, w); chk("pair1 grant", g, 0);
    @(posedge clk); #1; set_req(0, 1'b1, 2'd0, 8'h02, 8'h02);
    await_resp(0, 8'h01, alu_ref(2'd1, 8'hFD, 8'hFC) & 13'h1F, 1'b0, 3, 0, "pair1");
    await_grant(g, w); chk("pair2 grant", g, 1); chk("pair2 grant wait", w, 0);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    await_resp(1, 8'h0F, alu_ref(2'd2, 8'h05, 8'h03) & 13'h1F, 1'b0, 3, 0, "pair2");
    await_grant(g, w); chk("solo grant", g, 0);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    await_resp(0, 8'h04, alu_ref(2'd0, 8'h02, 8'h02) & 13'h1F, 1'b0, 3, 0, "solo");
    set_req(0, 1'b1, 2'd0, 8'h01, 8'h02);
    set_req(1, 1'b1, 2'd1, 8'h09, 8'h04);
    await_grant(g, w); chk("pair3 grant", g, 1);
    @(posedge clk); #1; req_valid[1] = 1'b0;
    await_resp(1, 8'h05, alu_ref(2'd1, 8'h09, 8'h04) & 13'h1F, 1'b0, 3, 0, "pair3a");
    await_grant(g, w); chk("pair3b grant", g, 0);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    await_resp(0, 8'h03, alu_ref(2'd0, 8'h01, 8'h02) & 13'h1F, 1'b0, 3, 0, "pair3b");

    // Backpressure: held response blocks req1, which is granted right after the take.
    reset_dut();
    set_req(1, 1'b1, 2'd2, 8'h05, 8'h03);
    run_vec('{0, 2'd0, 8'h03, 8'h04, 8'h07, 1'b0}, 5, "bp req0");
    #1; chk("bp req1 granted in idle", 32'(req_ready[1]), 1);
    run_vec('{1, 2'd2, 8'h05, 8'h03, 8'h0F, 1'b0}, 0, "bp req1");

    // Reset during WAIT drops the operation.
    reset_dut();
    set_req(0, 1'b1, 2'd0, 8'h05, 8'h06);
    await_grant(g, w);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid busy before reset", 32'(busy), 1);
    req_valid[1] = 1'b1;
    rst_n = 1'b0; #1;
    chk("mid reset ctl", {busy, alu_en, req_ready[0], req_ready[1], resp_valid[0], resp_valid[1], resp_err, owner}, 0);
    chk("mid reset data", {alu_a, alu_b, alu_op, resp_result, resp_carry, resp_flags}, 0);
    req_valid[1] = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2; chk("no resp after reset", {resp_valid[0], resp_valid[1], busy}, 0);
    run_vec('{0, 2'd0, 8'h01, 8'h01, 8'h02, 1'b0}, 0, "post reset");

    // ALU_LATENCY=3 instance: response at T+5, operands stable until capture.
    r3_op = 2'd0; r3_a = 8'd10; r3_b = 8'd20; r3_valid = 1'b1;
    #1; c = 0;
    while (!r3_ready && c < 20) begin @(posedge clk); #2; c++; end
    chk("L3 grant", 32'(r3_ready), 1);
    @(posedge clk); #1; r3_valid = 1'b0; #1;
    chk("L3 issue enable", 32'(alu3_en), 1);
    c = 1;
    while (!s3_valid0 && c < 40) begin
      chk("L3 operands held", {alu3_a, alu3_b, alu3_op}, {8'd10, 8'd20, 2'd0});
      @(posedge clk); #2; c++;
      if (c == 2) chk("L3 enable single", 32'(alu3_en), 0);
    end
    chk("L3 latency", c, 5);
    chk("L3 result", {s3_result, s3_err}, {8'd30, 1'b0});
    chk("L3 carry/flags", {s3_carry, s3_flags}, alu_ref(2'd0, 8'd10, 8'd20) & 13'h1F);
    s3_ready = 1'b1; @(posedge clk); #1; s3_ready = 1'b0; #1;
    chk("L3 idle after take", {busy3, s3_valid0}, 0);

    // Random traffic on the ALU_LATENCY=1 instance.
    reset_dut();
    fork
      drive_rand(0, 60);
      drive_rand(1, 60);
      sink_rand(0);
      sink_rand(1);
      monitor();
    join_none
    c = 0;
    while (got < 120 && c < 20000) begin @(posedge clk); c++; end
    chk("rand responses", got, 120);
    rnd_done = 1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one clocked 8-bit ALU (ops ADD/SUB/MULT/DIV, signed operands, result/carry_out/flags) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and picks between requesters round-robin.
- Drives the ALU's operand, operation and ENABLE inputs, waits a fixed ALU latency, and returns result/carry/flags on the owning requester's response channel.
- Sits between the ALU and the blocks issuing arithmetic (sequencers, test drivers).

Parameters:
WIDTH, 8, operand/result width; must match the ALU.
ALU_LATENCY, 1, clock edges from the ALU sampling ENABLE to alu_result being valid; legal range 1..15.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
req0_valid / req1_valid  input  1  request present.
req0_ready / req1_ready  output  1  request accepted this cycle.
req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed operands.
req0_op / req1_op  input  2  operation: 00 ADD, 01 SUB, 10 MULT, 11 DIV.
resp0_valid / resp1_valid  output  1  response held until taken.
resp0_ready / resp1_ready  input  1  response consumed.
resp_result  output  WIDTH  captured ALU result (shared by both channels).
resp_carry  output  1  captured carry_out.
resp_flags  output  4  captured ALU flags, passed through unmodified.
resp_err  output  1  divide-by-zero rejection.
alu_operand_a, alu_operand_b  output  WIDTH  to the ALU.
alu_operation  output  2  to the ALU.
alu_enable  output  1  to the ALU ENABLE.
alu_result  input  WIDTH  from the ALU.
alu_carry_out  input  1  from the ALU.
alu_flags  input  4  from the ALU.
busy  output  1  high in any state except IDLE.
owner  output  1  requester currently being served.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - All ready, resp_valid, alu_enable, busy and resp_err outputs go to 0.
  - alu_operand_a, alu_operand_b, alu_operation, resp_result, resp_carry and resp_flags go to 0.
  - The round-robin pointer points to req0, and owner goes to 0.
  - An operation in flight is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - reqN_ready is combinational: it is high only for the requester selected by the arbiter, and only when that requester's valid is high.
  - Selection: if only one requester is valid, grant it. If both are valid, grant the one the pointer names.
  - On a transfer (valid && ready) at cycle T: latch a, b, op and owner; the pointer moves to the other requester.
  - Next state: ISSUE. If op=DIV and b==0, next state is RESPOND instead, with resp_err=1, resp_result=0, carry=0, flags=0; the ALU is not touched.
- ISSUE (cycle T+1):
  - alu_enable=1 for exactly this cycle.
  - The ALU operand and operation outputs take the latched values and hold them until the state returns to IDLE.
- WAIT:
  - Lasts ALU_LATENCY cycles, tracked by a down-counter.
  - At the end of the last WAIT cycle, capture alu_result, alu_carry_out and alu_flags; resp_err=0.
- RESPOND:
  - respN_valid (owner only) is high from cycle T+2+ALU_LATENCY.
  - It stays high, with stable data, until respN_ready=1; the state then returns to IDLE on the next edge.
  - A response is never dropped or overwritten.
- Request handshake:
  - reqN_ready is 0 in every state except IDLE.
  - Requesters hold valid and payload stable until ready. Requests arriving while busy wait and are not lost.
- Throughput: one operation per 3+ALU_LATENCY cycles at minimum. There is no bypass from RESPOND into a new grant.
- resp_ready from the non-owner is ignored. resp_ready=1 while in RESPOND and the owner's valid is already high completes the transfer in that cycle.
- Signed arithmetic is the ALU's responsibility. The arbiter does no width conversion; operands pass through bit-exact.

Decomposition:
- Shared definitions file alu_defs.vh (the package equivalent, included with `include) holds:
  - op codes ADD/SUB/MULT/DIV;
  - the WIDTH default;
  - FSM state encodings (2-bit).
- One natural sub-module, rr_arb2:
  - Combinational grant from two valids plus a pointer.
  - Registered pointer update on an accept strobe.
  - Asynchronous active-low reset pointing to req0.

Test Plan:
- Single request: after reset, req0 ADD a=-5 b=-2 -> alu_enable pulses once at T+1; resp0_valid at T+3 (ALU_LATENCY=1) with resp_result=-7, resp_err=0; req1 channel stays idle.
- Simultaneous requests: req0 SUB -3,-4 and req1 MULT 5,3 both valid from reset -> req0 served first (result 1), then req1 (result 15); pointer alternates on a third pair, so req1 wins it.
- Backpressure: resp0_ready held 0 for 5 cycles -> resp0_valid and data stay stable and req1_ready stays 0 throughout; when resp0_ready=1, IDLE on the next cycle, then req1 is granted.
- Divide by zero: req1 DIV a=21 b=0 -> alu_enable never asserts; resp1_valid at T+1 with resp_err=1, result 0. Follow-up DIV 21,3 -> result 7, err 0.
- Reset mid-operation: assert RESET low during WAIT -> all outputs go to 0 immediately; after release, a new req0 ADD 1,1 completes normally with result 2.
- Latency parameter: with ALU_LATENCY=3, ADD 10,20 -> resp valid exactly at T+5; ALU operands held stable from ISSUE through the capture edge.
